dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the MM stage's load/store requests. Replaces the zero-latency combinational LSU RAM with a handshaked, fixed-latency byte-addressed data memory.
- Accepts one request at a time on a valid/ready interface and performs byte/half/word access with sign or zero extension.
- Returns a response carrying load data and writeback control.
- Drives a stall back to the pipeline while a request is in flight.

Parameters:
- width, 32, data word width in bits
- adrWidth, 24, byte-address width; memory holds 2**adrWidth bytes
- latency, 2, cycles from request accept to response valid; legal range 1..15
- rsWidth, 5, destination-register index width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- reqValid  input  1  request present
- reqReady  output  1  responder can accept a request
- reqWrite  input  1  1 = store, 0 = load
- reqAddress  input  adrWidth  byte address
- reqData  input  width  store data; bits [7:0] go to the lowest addressed byte
- reqAddressMode  input  3  0 = byte signed, 1 = half signed, 2 = word, 4 = byte unsigned, 5 = half unsigned
- reqRd  input  rsWidth  destination register of a load
- respValid  output  1  response present
- respReady  input  1  consumer takes the response
- respData  output  width  load result; 0 for stores and errors
- respRd  output  rsWidth  echoed reqRd for loads; 0 for stores and errors
- respWE  output  1  register-write enable: 1 for a successful load, else 0
- respErr  output  1  1 when reqAddressMode was 3, 6 or 7
- stallOut  output  1  pipeline stall request

Behaviour:
- States are IDLE, BUSY and RESP, with a 4-bit down-counter cnt.
- Reset takes priority over everything. On reset: state = IDLE, cnt = 0, and respValid, respData, respRd, respWE and respErr are all 0. RAM contents are not reset.
- reqReady = (state == IDLE) && !reset.
- IDLE:
  - A request is accepted when reqValid && reqReady at a rising edge.
  - On accept, latch address, data, mode, write and rd.
  - Set cnt = latency-1 and go to BUSY.
- BUSY:
  - While cnt != 0, decrement cnt.
  - When cnt == 0 at an edge, perform the access and go to RESP with respValid = 1.
- Timing: accept at edge N gives respValid high after edge N+latency.
- Store commits at that same edge, on the latched mode:
  - mode 0 writes 1 byte at the address.
  - mode 1 writes 2 bytes at {addr[adrWidth-1:1],0}.
  - mode 2 writes 4 bytes at {addr[adrWidth-1:2],00}.
  - Stores are little-endian.
  - Stores with mode 4 or 5 write nothing and are not errors.
  - Stores with mode 3, 6 or 7 write nothing and set respErr = 1.
- Load captures respData at that same edge:
  - Alignment: the low address bits are forced to 0 for half and word accesses. Misalignment is never an error.
  - Modes 0 and 1 sign-extend from bit 7 and bit 15 respectively.
  - Modes 4 and 5 zero-extend.
  - Mode 2 returns the full little-endian word.
  - A successful load gives respWE = 1 and respRd = latched rd.
  - Invalid mode gives respData = 0, respRd = 0, respWE = 0, respErr = 1.
- RESP:
  - Response outputs hold stable while respValid && !respReady.
  - On respReady, go to IDLE and clear respValid, respWE and respErr in the same edge; respData and respRd may hold.
  - A new request cannot be accepted in the cycle the response is consumed, because reqReady is 0 in RESP.
- stallOut = (state == BUSY) || (state == RESP && !respReady) || (state == IDLE && reqValid && reqWrite == 0). stallOut is combinational.
- Read-after-write: a load accepted after a store's response returns the stored bytes.
- Reset mid-operation:
  - Reset in BUSY drops the request; a pending store is not committed.
  - Reset in RESP discards the response.
- reqValid held high with changing fields while reqReady = 0 has no effect.

Test Plan:
- Store-then-load, latency = 2: store word 0xDEADBEEF to 0x000100 (mode 2).
  - respValid must rise exactly 2 edges after accept, with respWE = 0 and respErr = 0.
  - Load mode 0 at 0x000103 -> 0xFFFFFFDE with respWE = 1.
  - Load mode 4 at 0x000103 -> 0x000000DE.
  - Load mode 1 at 0x000102 -> 0xFFFFDEAD.
  - Load mode 5 at 0x000101 (aligned to 0x100) -> 0x0000BEEF.
- Byte store plus backpressure: store 0x80 mode 0 to 0x000200, then load mode 0 with reqRd = 7 while respReady is held 0 for 3 cycles.
  - respData = 0xFFFFFF80 and respRd = 7 must be stable throughout.
  - stallOut = 1 throughout.
  - reqReady = 0 until the edge after respReady = 1.
- Invalid mode: load mode 6 with reqRd = 3 -> respErr = 1, respData = 0, respRd = 0, respWE = 0.
  - A store with mode 7 to 0x000300 leaves that location unchanged on readback.
- Reset mid-store: store 0x11223344 to 0x000400, assert reset for 1 cycle while in BUSY.
  - All outputs must be 0 after the reset edge.
  - A later mode 2 load of 0x000400 returns the prior contents (0x00000000 if pre-loaded 0).
- Latency sweep: repeat the first scenario with latency = 1 and latency = 5.
  - Response edge must be N+1 and N+5.
  - stallOut must be high for exactly latency cycles when respReady is held 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked, fixed-latency byte-addressed data memory for MM-stage loads/stores.
// One request in flight; response carries load data and register writeback control.
module dmem_responder #(
   parameter int width    = 32,
   parameter int adrWidth = 24,
   parameter int latency  = 2,
   parameter int rsWidth  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reqValid,
   output logic                reqReady,
   input  logic                reqWrite,
   input  logic [adrWidth-1:0] reqAddress,
   input  logic [width-1:0]    reqData,
   input  logic [2:0]          reqAddressMode,
   input  logic [rsWidth-1:0]  reqRd,
   output logic                respValid,
   input  logic                respReady,
   output logic [width-1:0]    respData,
   output logic [rsWidth-1:0]  respRd,
   output logic                respWE,
   output logic                respErr,
   output logic                stallOut
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(latency - 1);

   state_t state, state_nxt;
   logic [3:0] cnt;

   logic [adrWidth-1:0] lat_addr;
   logic [width-1:0]    lat_data;
   logic [2:0]          lat_mode;
   logic                lat_write;
   logic [rsWidth-1:0]  lat_rd;

   logic [7:0] mem [2**adrWidth];

   logic [adrWidth-2:0] half_base;
   logic [adrWidth-3:0] word_base;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic [31:0]         word_v;
   logic [width-1:0]    load_val;
   logic                mode_bad;
   logic                accept;
   logic                finish;
   logic                commit;

   assign half_base = lat_addr[adrWidth-1:1];
   assign word_base = lat_addr[adrWidth-1:2];
   assign mode_bad  = (lat_mode == 3'd3) || (lat_mode == 3'd6) || (lat_mode == 3'd7);
   assign accept    = (state == IDLE) && reqValid && !reset;
   assign finish    = (state == BUSY) && (cnt == '0);
   // A reset landing on the commit edge must drop the store, so gate the write here.
   assign commit    = finish && lat_write && !reset;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (reqValid) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (respReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      reqReady = (state == IDLE) && !reset;
      stallOut = (state == BUSY)
              || ((state == RESP) && !respReady)
              || ((state == IDLE) && reqValid && !reqWrite);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         respValid <= 1'b0;
         respData  <= '0;
         respRd    <= '0;
         respWE    <= 1'b0;
         respErr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_addr  <= reqAddress;
                  lat_data  <= reqData;
                  lat_mode  <= reqAddressMode;
                  lat_write <= reqWrite;
                  lat_rd    <= reqRd;
                  cnt       <= CNT_INIT;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  respValid <= 1'b1;
                  if (mode_bad || lat_write) begin
                     respData <= '0;
                     respRd   <= '0;
                     respWE   <= 1'b0;
                     respErr  <= mode_bad;
                  end else begin
                     respData <= load_val;
                     respRd   <= lat_rd;
                     respWE   <= 1'b1;
                     respErr  <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (respReady) begin
                  respValid <= 1'b0;
                  respWE    <= 1'b0;
                  respErr   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         case (lat_mode)
            3'd0: mem[lat_addr] <= lat_data[7:0];
            3'd1: begin
               mem[{half_base, 1'b0}] <= lat_data[7:0];
               mem[{half_base, 1'b1}] <= lat_data[15:8];
            end
            3'd2: begin
               mem[{word_base, 2'b00}] <= lat_data[7:0];
               mem[{word_base, 2'b01}] <= lat_data[15:8];
               mem[{word_base, 2'b10}] <= lat_data[23:16];
               mem[{word_base, 2'b11}] <= lat_data[31:24];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_v   = mem[lat_addr];
      half_v   = {mem[{half_base, 1'b1}], mem[{half_base, 1'b0}]};
      word_v   = {mem[{word_base, 2'b11}], mem[{word_base, 2'b10}],
                  mem[{word_base, 2'b01}], mem[{word_base, 2'b00}]};
      load_val = '0;
      case (lat_mode)
         3'd0:    load_val = {{(width-8){byte_v[7]}}, byte_v};
         3'd1:    load_val = {{(width-16){half_v[15]}}, half_v};
         3'd2:    load_val = width'(word_v);
         3'd4:    load_val = width'(byte_v);
         3'd5:    load_val = width'(half_v);
         default: load_val = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at latency 2, 1 and 5
// share one clock; a byte-level memory model predicts every response.
module tb_dmem_responder;

   localparam int N = 3;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset       [N];
   logic        req_valid   [N];
   logic        req_ready   [N];
   logic        req_write   [N];
   logic [23:0] req_address [N];
   logic [31:0] req_data    [N];
   logic [2:0]  req_mode    [N];
   logic [4:0]  req_rd      [N];
   logic        resp_valid  [N];
   logic        resp_ready  [N];
   logic [31:0] resp_data   [N];
   logic [4:0]  resp_rd     [N];
   logic        resp_we     [N];
   logic        resp_err    [N];
   logic        stall       [N];

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];
   logic [7:0] mdl [longint];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .width(32),
         .adrWidth(24),
         .latency((g == 0) ? 2 : (g == 1) ? 1 : 5),
         .rsWidth(5)
      ) u_dut (
         .clk(clk),
         .reset(reset[g]),
         .reqValid(req_valid[g]),
         .reqReady(req_ready[g]),
         .reqWrite(req_write[g]),
         .reqAddress(req_address[g]),
         .reqData(req_data[g]),
         .reqAddressMode(req_mode[g]),
         .reqRd(req_rd[g]),
         .respValid(resp_valid[g]),
         .respReady(resp_ready[g]),
         .respData(resp_data[g]),
         .respRd(resp_rd[g]),
         .respWE(resp_we[g]),
         .respErr(resp_err[g]),
         .stallOut(stall[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 5;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rd_b(input int k, input logic [23:0] a);
      longint key = (longint'(k) << 24) | longint'(a);
      return mdl.exists(key) ? mdl[key] : 8'h00;
   endfunction

   function automatic void wr_b(input int k, input logic [23:0] a, input logic [7:0] v);
      mdl[(longint'(k) << 24) | longint'(a)] = v;
   endfunction

   function automatic exp_t model(input int k, input logic wr, input logic [23:0] a,
                                  input logic [31:0] d, input logic [2:0] m, input logic [4:0] rd);
      exp_t e;
      logic [23:0] ah, aw;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      ah = a & 24'hFFFFFE;
      aw = a & 24'hFFFFFC;
      e  = '{data: 32'h0, rd: 5'h0, we: 1'b0, err: 1'b0};
      if (m == 3'd3 || m == 3'd6 || m == 3'd7) begin
         e.err = 1'b1;
         return e;
      end
      if (wr) begin
         if (m == 3'd0) wr_b(k, a, d[7:0]);
         if (m == 3'd1) begin
            wr_b(k, ah, d[7:0]);
            wr_b(k, ah + 24'd1, d[15:8]);
         end
         if (m == 3'd2) begin
            for (int i = 0; i < 4; i++) wr_b(k, aw + 24'(i), d[8*i +: 8]);
         end
         return e;
      end
      b = rd_b(k, a);
      h = {rd_b(k, ah + 24'd1), rd_b(k, ah)};
      w = {rd_b(k, aw + 24'd3), rd_b(k, aw + 24'd2), rd_b(k, aw + 24'd1), rd_b(k, aw)};
      case (m)
         3'd0:    e.data = {{24{b[7]}}, b};
         3'd1:    e.data = {{16{h[15]}}, h};
         3'd2:    e.data = w;
         3'd4:    e.data = {24'h0, b};
         default: e.data = {16'h0, h};
      endcase
      e.rd = rd;
      e.we = 1'b1;
      return e;
   endfunction

   // Called at #1 after a clock edge with the DUT idle.
   task automatic xfer(input int k, input logic wr, input logic [23:0] a, input logic [31:0] d,
                       input logic [2:0] m, input logic [4:0] rd, input int hold);
      exp_t e;
      int   edges;
      int   stalls;
      resp_ready[k]  = (hold == 0);
      req_write[k]   = wr;
      req_address[k] = a;
      req_data[k]    = d;
      req_mode[k]    = m;
      req_rd[k]      = rd;
      req_valid[k]   = 1'b1;
      #1;
      check("req_ready_idle", 32'(req_ready[k]), 32'd1);
      check("stall_idle_req", 32'(stall[k]), 32'(!wr));
      sb.push_back(model(k, wr, a, d, m, rd));
      @(posedge clk); #1;
      // keep valid high with junk fields while busy: must not be taken
      req_write[k]   = 1'($urandom);
      req_address[k] = 24'($urandom);
      req_data[k]    = $urandom;
      req_mode[k]    = 3'($urandom);
      req_rd[k]      = 5'($urandom);
      edges  = 0;
      stalls = 0;
      while (!resp_valid[k] && edges < 40) begin
         stalls += int'(stall[k]);
         @(posedge clk); #1;
         edges++;
      end
      req_valid[k] = 1'b0;
      check("resp_edge", 32'(edges), 32'(lat_of(k)));
      check("stall_cycles", 32'(stalls), 32'(lat_of(k)));
      e = sb.pop_front();
      check("resp_data", resp_data[k], e.data);
      check("resp_rd", 32'(resp_rd[k]), 32'(e.rd));
      check("resp_we", 32'(resp_we[k]), 32'(e.we));
      check("resp_err", 32'(resp_err[k]), 32'(e.err));
      if (hold > 0) begin
         repeat (hold) begin
            check("bp_stall", 32'(stall[k]), 32'd1);
            check("bp_req_ready", 32'(req_ready[k]), 32'd0);
            @(posedge clk); #1;
            check("bp_valid", 32'(resp_valid[k]), 32'd1);
            check("bp_data", resp_data[k], e.data);
            check("bp_rd", 32'(resp_rd[k]), 32'(e.rd));
         end
         resp_ready[k] = 1'b1;
         #1;
         check("bp_stall_release", 32'(stall[k]), 32'd0);
         check("bp_req_ready_release", 32'(req_ready[k]), 32'd0);
      end
      @(posedge clk); #1;
      check("valid_clear", 32'(resp_valid[k]), 32'd0);
      check("we_clear", 32'(resp_we[k]), 32'd0);
      check("err_clear", 32'(resp_err[k]), 32'd0);
      check("req_ready_back", 32'(req_ready[k]), 32'd1);
   endtask

   task automatic reset_busy(input int k, input logic [23:0] a, input logic [31:0] d);
      resp_ready[k]  = 1'b1;
      req_write[k]   = 1'b1;
      req_address[k] = a;
      req_data[k]    = d;
      req_mode[k]    = 3'd2;
      req_valid[k]   = 1'b1;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      reset[k]     = 1'b1;
      @(posedge clk); #1;
      check("rst_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_data", resp_data[k], 32'd0);
      check("rst_rd", 32'(resp_rd[k]), 32'd0);
      check("rst_we", 32'(resp_we[k]), 32'd0);
      check("rst_err", 32'(resp_err[k]), 32'd0);
      check("rst_req_ready", 32'(req_ready[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'd0);
      reset[k] = 1'b0;
      #1;
      check("rst_req_ready_after", 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         reset[k]       = 1'b1;
         req_valid[k]   = 1'b0;
         req_write[k]   = 1'b0;
         req_address[k] = '0;
         req_data[k]    = '0;
         req_mode[k]    = '0;
         req_rd[k]      = '0;
         resp_ready[k]  = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check("init_valid", 32'(resp_valid[k]), 32'd0);
         check("init_data", resp_data[k], 32'd0);
         check("init_rd", 32'(resp_rd[k]), 32'd0);
         check("init_we", 32'(resp_we[k]), 32'd0);
         check("init_err", 32'(resp_err[k]), 32'd0);
         check("init_req_ready", 32'(req_ready[k]), 32'd0);
         reset[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < N; k++) check("init_ready_rel", 32'(req_ready[k]), 32'd1);

      for (int k = 0; k < N; k++) begin
         xfer(k, 1'b1, 24'h000100, 32'hDEADBEEF, 3'd2, 5'd9, 0);
         xfer(k, 1'b0, 24'h000103, 32'h0, 3'd0, 5'd1, 0);
         xfer(k, 1'b0, 24'h000103, 32'h0, 3'd4, 5'd2, 0);
         xfer(k, 1'b0, 24'h000102, 32'h0, 3'd1, 5'd4, 0);
         xfer(k, 1'b0, 24'h000101, 32'h0, 3'd5, 5'd5, 0);
         xfer(k, 1'b0, 24'h000102, 32'h0, 3'd2, 5'd6, 0);
      end

      xfer(0, 1'b1, 24'h000200, 32'h12345680, 3'd0, 5'd0, 0);
      xfer(0, 1'b0, 24'h000200, 32'h0, 3'd0, 5'd7, 3);
      xfer(0, 1'b0, 24'h000200, 32'h0, 3'd6, 5'd3, 0);

      xfer(0, 1'b1, 24'h000300, 32'hCAFEF00D, 3'd2, 5'd0, 0);
      xfer(0, 1'b1, 24'h000300, 32'h11111111, 3'd7, 5'd0, 0);
      xfer(0, 1'b1, 24'h000300, 32'h22222222, 3'd4, 5'd0, 0);
      xfer(0, 1'b0, 24'h000300, 32'h0, 3'd2, 5'd10, 0);
      xfer(0, 1'b1, 24'h000301, 32'h9876ABCD, 3'd1, 5'd0, 0);
      xfer(0, 1'b0, 24'h000303, 32'h0, 3'd2, 5'd11, 0);

      xfer(0, 1'b1, 24'h000400, 32'hA5A5A5A5, 3'd2, 5'd0, 0);
      reset_busy(0, 24'h000400, 32'h11223344);
      xfer(0, 1'b0, 24'h000400, 32'h0, 3'd2, 5'd12, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
